// File: rtl/special_multiply_seq.sv
// Sequential special-multiply: piecewise +1 / x2 / x2-1 on a latched operand, serial
// double-dabble BCD conversion, multiplexed common-anode 7-segment scan. Optional macro: LEAD_ZERO_BLANK_EN.
module special_multiply_seq #(
    parameter int IN_W        = 4,
    parameter int THRESH_LO   = 3,
    parameter int THRESH_HI   = 6,
    parameter int MAX_IN      = 8,
    parameter int DIGITS      = 2,
    parameter int REFRESH_DIV = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IN_W:0]     result,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an_n
);

    localparam int RES_W  = IN_W + 1;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(RES_W + 1);
    localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [RES_W-1:0]  LO_R      = RES_W'(THRESH_LO);
    localparam logic [RES_W-1:0]  HI_R      = RES_W'(THRESH_HI);
    localparam logic [RES_W-1:0]  MAX_R     = RES_W'(MAX_IN);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RES_W - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_reg;
    logic [IN_W-1:0]    x_reg;
    logic [RES_W-1:0]   bin_reg;
    logic [RES_W-1:0]   res_pend_reg;
    logic               err_pend_reg;
    logic [BCD_W-1:0]   bcd_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BCD_W-1:0]   disp_bcd_reg;
    logic [SCAN_W-1:0]  scan_cnt_reg;
    logic [DIG_W-1:0]   digit_idx_reg;

    logic [RES_W-1:0]   xe;
    logic [RES_W-1:0]   calc_res;
    logic               calc_err;
    logic [BCD_W-1:0]   bcd_adj;

    // Piecewise rule; out-of-range operands yield 0 with the error flag.
    always_comb begin
        xe       = {1'b0, x_reg};
        calc_res = '0;
        calc_err = 1'b0;
        if (xe > MAX_R) begin
            calc_err = 1'b1;
        end else if (xe < LO_R) begin
            calc_res = xe + RES_W'(1);
        end else if (xe < HI_R) begin
            calc_res = xe << 1;
        end else begin
            calc_res = (xe << 1) - RES_W'(1);
        end
    end

    // Add-3 correction applied to every nibble before each shift.
    always_comb begin
        bcd_adj = bcd_reg;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            bin_reg      <= '0;
            res_pend_reg <= '0;
            err_pend_reg <= 1'b0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            disp_bcd_reg <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            result       <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        x_reg     <= in;
                        busy      <= 1'b1;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    bin_reg      <= calc_res;
                    res_pend_reg <= calc_res;
                    err_pend_reg <= calc_err;
                    bcd_reg      <= '0;
                    cnt_reg      <= '0;
                    state_reg    <= CONV;
                end
                CONV: begin
                    bcd_reg <= (bcd_adj << 1) | BCD_W'(bin_reg[RES_W-1]);
                    bin_reg <= bin_reg << 1;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_LAST) begin
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done         <= 1'b1;
                    result       <= res_pend_reg;
                    err          <= err_pend_reg;
                    disp_bcd_reg <= bcd_reg;
                    state_reg    <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= '0;
        end else if (scan_cnt_reg == SCAN_LAST) begin
            scan_cnt_reg  <= '0;
            digit_idx_reg <= (digit_idx_reg == DIG_LAST) ? '0 : digit_idx_reg + DIG_W'(1);
        end else begin
            scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
        end
    end

    function automatic logic [6:0] decode_digit(input logic [3:0] nib);
        case (nib)
            4'd0:    decode_digit = 7'b1000000;
            4'd1:    decode_digit = 7'b1111001;
            4'd2:    decode_digit = 7'b0100100;
            4'd3:    decode_digit = 7'b0110000;
            4'd4:    decode_digit = 7'b0011001;
            4'd5:    decode_digit = 7'b0010010;
            4'd6:    decode_digit = 7'b0000010;
            4'd7:    decode_digit = 7'b1111000;
            4'd8:    decode_digit = 7'b0000000;
            4'd9:    decode_digit = 7'b0010000;
            default: decode_digit = 7'b1111111;
        endcase
    endfunction

    logic [3:0]        nibble [DIGITS];
    logic [DIGITS-1:0] blank;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibble[gi] = disp_bcd_reg[4*gi +: 4];
            assign an_n[gi]   = (digit_idx_reg != DIG_W'(gi));
        end
    endgenerate

`ifdef LEAD_ZERO_BLANK_EN
    // A digit blanks when it and every more-significant nibble are zero; units never blank.
    assign blank[0] = 1'b0;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_blank
            assign blank[gi] = (disp_bcd_reg[BCD_W-1:4*gi] == '0);
        end
    endgenerate
`else
    assign blank = '0;
`endif

    always_comb begin
        seg = decode_digit(nibble[digit_idx_reg]);
        if (blank[digit_idx_reg]) begin
            seg = 7'b1111111;
        end
    end

endmodule

// File: tb/tb_special_multiply_seq.sv
// Directed bench for special_multiply_seq: scoreboard of expected results, display scan and reset checks.
module tb_special_multiply_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_op;
    logic       start;
    logic       busy, done, err;
    logic [4:0] result;
    logic [6:0] seg;
    logic [1:0] an_n;

`ifdef LEAD_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] res;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    special_multiply_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .in     (in_op),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .result (result),
        .seg    (seg),
        .an_n   (an_n)
    );

    function automatic exp_t model(input int x);
        exp_t e;
        e.res = '0;
        e.err = 1'b0;
        if (x > 8)      e.err = 1'b1;
        else if (x < 3) e.res = 5'(x + 1);
        else if (x < 6) e.res = 5'(2 * x);
        else            e.res = 5'(2 * x - 1);
        return e;
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction; with spam, start stays high and in changes every cycle while busy.
    task automatic do_op(input logic [3:0] x, input bit spam);
        exp_t e;
        int   k = 0;
        int   busy_cnt = 0;
        int   extra = 0;
        bit   seen = 1'b0;
        sb.push_back(model(int'(x)));
        in_op = x;
        start = 1'b1;
        step();
        if (busy) busy_cnt++;
        if (!spam) start = 1'b0;
        while (!seen && k < 20) begin
            if (spam) in_op = 4'($urandom);
            step();
            k++;
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        start = 1'b0;
        check("latency", k, 7);
        check("busy_cycles", busy_cnt, 6);
        e = sb.pop_front();
        check("result", {27'd0, result}, {27'd0, e.res});
        check("err", {31'd0, err}, {31'd0, e.err});
        $display("[TB] op in=%0d spam=%0d -> result=%0d err=%0d latency=%0d", x, spam, result, err, k);
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) extra++;
        end
        check("no_extra_done", extra, 0);
    endtask

    task automatic check_display(input int val);
        bit         su = 1'b0;
        bit         st = 1'b0;
        logic [6:0] gu = 'x;
        logic [6:0] gt = 'x;
        int         bad = 0;
        int         tens = val / 10;
        logic [6:0] exp_t_seg;
        exp_t_seg = (LZB && tens == 0) ? 7'b1111111 : seg_of(tens);
        for (int i = 0; i < 80; i++) begin
            step();
            if (an_n == 2'b10) begin
                su = 1'b1;
                gu = seg;
            end else if (an_n == 2'b01) begin
                st = 1'b1;
                gt = seg;
            end else begin
                bad++;
            end
        end
        check("an_n_onehot", bad, 0);
        check("units_seen", {31'd0, su}, 32'd1);
        check("tens_seen", {31'd0, st}, 32'd1);
        check("seg_units", {25'd0, gu}, {25'd0, seg_of(val % 10)});
        check("seg_tens", {25'd0, gt}, {25'd0, exp_t_seg});
        $display("[TB] display val=%0d units=%b tens=%b", val, gu, gt);
    endtask

    task automatic check_period();
        logic [1:0] prev;
        int         k = 0;
        int         n = 0;
        prev = an_n;
        while (an_n == prev && k < 40) begin
            step();
            k++;
        end
        prev = an_n;
        while (an_n == prev && n < 40) begin
            step();
            n++;
        end
        check("scan_period", n, 16);
        $display("[TB] scan period=%0d", n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int extra;
        rst_n = 1'b0;
        in_op = '0;
        start = 1'b0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_result", {27'd0, result}, 32'd0);
        check("rst_an_n", {30'd0, an_n}, 32'd1 << 1);
        check("rst_seg", {25'd0, seg}, 32'h40);
        step();
        rst_n = 1'b1;
        step();

        do_op(4'd0, 1'b0);
        check_display(1);
        do_op(4'd3, 1'b0);
        check_display(6);
        do_op(4'd6, 1'b0);
        check_display(11);
        do_op(4'd9, 1'b0);
        check_display(0);
        do_op(4'd2, 1'b0);
        check_display(3);
        do_op(4'd5, 1'b1);
        check_display(10);
        do_op(4'd8, 1'b0);
        check_display(15);
        check_period();

        // Reset in the middle of conversion.
        in_op = 4'd7;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_result", {27'd0, result}, 32'd0);
        check("midrst_an_n", {30'd0, an_n}, 32'd2);
        check("midrst_seg", {25'd0, seg}, 32'h40);
        #3 rst_n = 1'b1;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done) extra++;
        end
        check("midrst_no_done", extra, 0);
        $display("[TB] reset during conversion, done pulses after=%0d", extra);
        check_display(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
